// File: rtl/renode_axi_pkg.sv
// Shared AXI types and helpers used by the Renode AXI bridge blocks.
package renode_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } response_e;

  typedef logic [2:0] burst_size_t;
  typedef logic [7:0] burst_length_t;

  // Element [0] is the shortest legal WRAP length.
  localparam logic [3:0][7:0] WrapLengths = {8'd15, 8'd7, 8'd3, 8'd1};

  // Response encodings happen to be ordered by severity.
  function automatic response_e worst_response(response_e a, response_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/renode_axi_burst_addr_gen.sv
// Combinational next-beat address generator and burst legality check.
module renode_axi_burst_addr_gen
  import renode_axi_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) (
  input  logic [AddressWidth-1:0] addr,
  input  burst_length_t           len,
  input  burst_size_t             size,
  input  logic [1:0]              burst,
  output logic [AddressWidth-1:0] next_addr,
  output logic                    legal
);

  localparam int StrbWidth = DataWidth / 8;

  logic [AddressWidth-1:0] bytes_s;
  logic [AddressWidth-1:0] incr_s;
  logic [AddressWidth-1:0] boundary_s;
  logic [AddressWidth-1:0] mask_s;
  logic                    wrap_len_ok_s;

  assign bytes_s    = AddressWidth'(1'b1) << size;
  assign incr_s     = addr + bytes_s;
  assign boundary_s = (AddressWidth'(len) + AddressWidth'(1'b1)) * bytes_s;
  assign mask_s     = boundary_s - AddressWidth'(1'b1);

  // WRAP is only defined for 2, 4, 8 or 16 beats.
  always_comb begin
    wrap_len_ok_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wrap_len_ok_s = wrap_len_ok_s | (len == WrapLengths[i]);
    end
  end

  // Next address per burst type, plus the checks that keep bad bursts away from Renode.
  always_comb begin
    next_addr = addr;
    legal     = 1'b1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_s;
      BURST_WRAP: begin
        next_addr = (addr & ~mask_s) | (incr_s & mask_s);
        legal     = wrap_len_ok_s && ((addr & (bytes_s - AddressWidth'(1'b1))) == '0);
      end
      default: legal = 1'b0;
    endcase
    if (bytes_s > AddressWidth'(StrbWidth)) begin
      legal = 1'b0;
    end else begin
      legal = legal;
    end
  end

endmodule

// File: rtl/renode_axi_burst_converter.sv
// Splits upstream AXI4 bursts into single-beat INCR transactions and reassembles the responses.
module renode_axi_burst_converter
  import renode_axi_pkg::*;
#(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [TransactionIdWidth-1:0] s_awid,
  input  logic [AddressWidth-1:0]       s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic [1:0]                    s_awburst,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  input  logic [DataWidth-1:0]          s_wdata,
  input  logic [DataWidth/8-1:0]        s_wstrb,
  input  logic                          s_wlast,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  output logic [TransactionIdWidth-1:0] s_bid,
  output logic [1:0]                    s_bresp,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  input  logic [TransactionIdWidth-1:0] s_arid,
  input  logic [AddressWidth-1:0]       s_araddr,
  input  logic [7:0]                    s_arlen,
  input  logic [2:0]                    s_arsize,
  input  logic [1:0]                    s_arburst,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [TransactionIdWidth-1:0] s_rid,
  output logic [DataWidth-1:0]          s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [TransactionIdWidth-1:0] m_awid,
  output logic [AddressWidth-1:0]       m_awaddr,
  output logic [7:0]                    m_awlen,
  output logic [2:0]                    m_awsize,
  output logic [1:0]                    m_awburst,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [DataWidth-1:0]          m_wdata,
  output logic [DataWidth/8-1:0]        m_wstrb,
  output logic                          m_wlast,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  input  logic [TransactionIdWidth-1:0] m_bid,
  input  logic [1:0]                    m_bresp,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [TransactionIdWidth-1:0] m_arid,
  output logic [AddressWidth-1:0]       m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [TransactionIdWidth-1:0] m_rid,
  input  logic [DataWidth-1:0]          m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast
);

  typedef enum logic [2:0] {
    R_IDLE = 3'd0, R_ADDR = 3'd1, R_DATA = 3'd2, R_SEND = 3'd3, R_ERR = 3'd4
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0, W_ADDR = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3, W_BRESP = 3'd4, W_DRAIN = 3'd5
  } w_state_e;

  r_state_e                r_state_r;
  w_state_e                w_state_r;
  logic [AddressWidth-1:0] ar_addr_r, aw_addr_r;
  burst_length_t           ar_len_r, aw_len_r, r_beat_r, w_beat_r;
  burst_size_t             ar_size_r, aw_size_r;
  logic [1:0]              ar_burst_r, aw_burst_r;
  response_e               bresp_acc_r, b_merged_s;
  logic                    wlast_err_r;

  logic [AddressWidth-1:0] ar_gen_addr_s, aw_gen_addr_s, ar_next_s, aw_next_s;
  burst_length_t           ar_gen_len_s, aw_gen_len_s;
  burst_size_t             ar_gen_size_s, aw_gen_size_s;
  logic [1:0]              ar_gen_burst_s, aw_gen_burst_s;
  logic                    ar_legal_s, aw_legal_s;
  logic                    unused_s;

  assign m_arlen   = 8'd0;
  assign m_awlen   = 8'd0;
  assign m_arburst = BURST_INCR;
  assign m_awburst = BURST_INCR;
  assign b_merged_s = worst_response(bresp_acc_r, response_e'(m_bresp));
  assign unused_s  = ^{m_rid, m_rlast, m_bid};

  // While idle the generators judge the incoming request; afterwards they step the held burst.
  always_comb begin
    if (r_state_r == R_IDLE) begin
      ar_gen_addr_s = s_araddr; ar_gen_len_s = s_arlen;
      ar_gen_size_s = s_arsize; ar_gen_burst_s = s_arburst;
    end else begin
      ar_gen_addr_s = ar_addr_r; ar_gen_len_s = ar_len_r;
      ar_gen_size_s = ar_size_r; ar_gen_burst_s = ar_burst_r;
    end
    if (w_state_r == W_IDLE) begin
      aw_gen_addr_s = s_awaddr; aw_gen_len_s = s_awlen;
      aw_gen_size_s = s_awsize; aw_gen_burst_s = s_awburst;
    end else begin
      aw_gen_addr_s = aw_addr_r; aw_gen_len_s = aw_len_r;
      aw_gen_size_s = aw_size_r; aw_gen_burst_s = aw_burst_r;
    end
  end

  renode_axi_burst_addr_gen #(.AddressWidth(AddressWidth), .DataWidth(DataWidth)) u_ar_gen (
    .addr(ar_gen_addr_s), .len(ar_gen_len_s), .size(ar_gen_size_s), .burst(ar_gen_burst_s),
    .next_addr(ar_next_s), .legal(ar_legal_s)
  );

  renode_axi_burst_addr_gen #(.AddressWidth(AddressWidth), .DataWidth(DataWidth)) u_aw_gen (
    .addr(aw_gen_addr_s), .len(aw_gen_len_s), .size(aw_gen_size_s), .burst(aw_gen_burst_s),
    .next_addr(aw_next_s), .legal(aw_legal_s)
  );

  // Read path: one downstream single-beat read per upstream beat, or local SLVERR beats.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_r <= R_IDLE;
      ar_addr_r <= '0; ar_len_r <= '0; ar_size_r <= '0; ar_burst_r <= '0; r_beat_r <= '0;
      s_arready <= 1'b0; s_rvalid <= 1'b0; s_rid <= '0; s_rdata <= '0; s_rresp <= '0; s_rlast <= 1'b0;
      m_arvalid <= 1'b0; m_arid <= '0; m_araddr <= '0; m_arsize <= '0; m_rready <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (s_arready && s_arvalid) begin
            s_arready  <= 1'b0;
            ar_addr_r  <= s_araddr; ar_len_r <= s_arlen;
            ar_size_r  <= s_arsize; ar_burst_r <= s_arburst;
            r_beat_r   <= 8'd0;
            s_rid      <= s_arid; m_arid <= s_arid;
            m_arsize   <= s_arsize; m_araddr <= s_araddr;
            if (ar_legal_s) begin
              m_arvalid <= 1'b1;
              r_state_r <= R_ADDR;
            end else begin
              s_rvalid  <= 1'b1;
              s_rdata   <= '0;
              s_rresp   <= RESP_SLVERR;
              s_rlast   <= (s_arlen == 8'd0);
              r_state_r <= R_ERR;
            end
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          r_state_r <= R_DATA;
        end
        R_DATA: if (m_rvalid) begin
          m_rready  <= 1'b0;
          s_rvalid  <= 1'b1;
          s_rdata   <= m_rdata;
          s_rresp   <= m_rresp;
          s_rlast   <= (r_beat_r == ar_len_r);
          r_state_r <= R_SEND;
        end
        R_SEND: if (s_rready) begin
          s_rvalid <= 1'b0;
          s_rlast  <= 1'b0;
          if (r_beat_r == ar_len_r) begin
            s_arready <= 1'b1;
            r_state_r <= R_IDLE;
          end else begin
            r_beat_r  <= r_beat_r + 8'd1;
            ar_addr_r <= ar_next_s;
            m_araddr  <= ar_next_s;
            m_arvalid <= 1'b1;
            r_state_r <= R_ADDR;
          end
        end
        R_ERR: if (s_rready) begin
          if (r_beat_r == ar_len_r) begin
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_arready <= 1'b1;
            r_state_r <= R_IDLE;
          end else begin
            r_beat_r <= r_beat_r + 8'd1;
            s_rlast  <= ((r_beat_r + 8'd1) == ar_len_r);
          end
        end
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

  // Write path: one outstanding downstream write at a time, responses folded into one B.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_r <= W_IDLE;
      aw_addr_r <= '0; aw_len_r <= '0; aw_size_r <= '0; aw_burst_r <= '0; w_beat_r <= '0;
      bresp_acc_r <= RESP_OKAY; wlast_err_r <= 1'b0;
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_bid <= '0; s_bresp <= '0;
      m_awvalid <= 1'b0; m_awid <= '0; m_awaddr <= '0; m_awsize <= '0;
      m_wvalid <= 1'b0; m_wdata <= '0; m_wstrb <= '0; m_wlast <= 1'b0; m_bready <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (s_awready && s_awvalid) begin
            s_awready   <= 1'b0;
            aw_addr_r   <= s_awaddr; aw_len_r <= s_awlen;
            aw_size_r   <= s_awsize; aw_burst_r <= s_awburst;
            w_beat_r    <= 8'd0;
            bresp_acc_r <= RESP_OKAY;
            wlast_err_r <= 1'b0;
            s_bid       <= s_awid; m_awid <= s_awid;
            m_awsize    <= s_awsize; m_awaddr <= s_awaddr;
            if (aw_legal_s) begin
              m_awvalid <= 1'b1;
              w_state_r <= W_ADDR;
            end else begin
              s_wready  <= 1'b1;
              w_state_r <= W_DRAIN;
            end
          end else begin
            s_awready <= 1'b1;
          end
        end
        W_ADDR: if (m_awready) begin
          m_awvalid <= 1'b0;
          s_wready  <= 1'b1;
          w_state_r <= W_DATA;
        end
        W_DATA: begin
          if (s_wready) begin
            if (s_wvalid) begin
              s_wready <= 1'b0;
              m_wvalid <= 1'b1;
              m_wlast  <= 1'b1;
              m_wdata  <= s_wdata;
              m_wstrb  <= s_wstrb;
              if (s_wlast != (w_beat_r == aw_len_r)) wlast_err_r <= 1'b1;
            end
          end else if (m_wready) begin
            m_wvalid  <= 1'b0;
            m_wlast   <= 1'b0;
            m_bready  <= 1'b1;
            w_state_r <= W_RESP;
          end
        end
        W_RESP: if (m_bvalid) begin
          m_bready <= 1'b0;
          if (w_beat_r == aw_len_r) begin
            s_bvalid  <= 1'b1;
            s_bresp   <= wlast_err_r ? worst_response(b_merged_s, RESP_SLVERR) : b_merged_s;
            w_state_r <= W_BRESP;
          end else begin
            bresp_acc_r <= b_merged_s;
            w_beat_r    <= w_beat_r + 8'd1;
            aw_addr_r   <= aw_next_s;
            m_awaddr    <= aw_next_s;
            m_awvalid   <= 1'b1;
            w_state_r   <= W_ADDR;
          end
        end
        W_BRESP: if (s_bready) begin
          s_bvalid  <= 1'b0;
          s_awready <= 1'b1;
          w_state_r <= W_IDLE;
        end
        W_DRAIN: if (s_wvalid) begin
          if (w_beat_r == aw_len_r) begin
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b1;
            s_bresp   <= RESP_SLVERR;
            w_state_r <= W_BRESP;
          end else begin
            w_beat_r <= w_beat_r + 8'd1;
          end
        end
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

endmodule
